// File: rtl/commit_trace_fifo.sv
// Show-ahead FIFO that buffers retired instructions for a trace consumer.
// Optional per-entry cycle stamp is built when COMMIT_TRACE_STAMP_EN is defined.
module commit_trace_fifo #(
    parameter int WIDTH = 31,
    parameter int REG   = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     globalReset,
    input  logic                     commitValid,
    input  logic [WIDTH:0]           commitResult,
    input  logic [REG:0]             commitDest,
    input  logic [WIDTH:0]           commitPC,
    input  logic                     commitFlush,
    input  logic                     traceReady,
    input  logic                     clearOverflow,
    output logic                     traceValid,
    output logic [WIDTH:0]           traceResult,
    output logic [REG:0]             traceDest,
    output logic [WIDTH:0]           tracePC,
    output logic                     traceFlush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              retiredCount
`ifdef COMMIT_TRACE_STAMP_EN
    ,
    output logic [31:0]              traceStamp
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = WIDTH + 1;
    localparam int RW = REG + 1;
`ifdef COMMIT_TRACE_STAMP_EN
    localparam int EW = 2 * DW + RW + 1 + 32;
`else
    localparam int EW = 2 * DW + RW + 1;
`endif

    typedef logic [EW-1:0] entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          entry_in;
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     retired_q, retired_d;
    logic            push, pop, drop;

`ifdef COMMIT_TRACE_STAMP_EN
    logic [31:0]     cycle_q, cycle_d;

    assign cycle_d  = cycle_q + 32'd1;
    assign entry_in = {cycle_q, commitFlush, commitPC, commitDest, commitResult};
`else
    assign entry_in = {commitFlush, commitPC, commitDest, commitResult};
`endif

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign traceValid = !empty;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign retiredCount = retired_q;

    // Popping frees a slot, so a full FIFO still accepts a commit in that cycle.
    assign pop  = traceValid && traceReady;
    assign push = commitValid && (!full || pop);
    assign drop = commitValid && full && !pop;

    assign head        = mem_q[rd_ptr_q];
    assign traceResult = head[DW-1:0];
    assign traceDest   = head[DW +: RW];
    assign tracePC     = head[DW+RW +: DW];
    assign traceFlush  = head[2*DW+RW];
`ifdef COMMIT_TRACE_STAMP_EN
    assign traceStamp  = head[EW-1 -: 32];
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        retired_d  = retired_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A fresh drop wins over a simultaneous clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end
        if (commitValid) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            retired_q  <= '0;
`ifdef COMMIT_TRACE_STAMP_EN
            cycle_q    <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            retired_q  <= retired_d;
`ifdef COMMIT_TRACE_STAMP_EN
            cycle_q    <= cycle_d;
`endif
        end
    end

endmodule
